// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arb_pkg
//  Purpose  : Shared types and constants for the two-port ALU arbiter.
//             FSM state enumeration, requester ids, default widths/latency.
//  Revision : 1.0  initial release
// ============================================================================
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam int c_DW_DEF      = 8;
    localparam int c_OPW_DEF     = 4;
    localparam int c_ALU_LAT_DEF = 1;

endpackage : alu_arb_pkg
`default_nettype wire

// File: rtl/alu_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-input round-robin picker, purely combinational.
//             When both inputs request, the one that did not win last time
//             is chosen; otherwise the sole requester wins.
//  Ports    : req[1:0] in  - request vector
//             last     in  - id of the previous winner
//             gnt[1:0] out - one-hot grant (all zero when nothing requested)
//             id       out - winner id (REQ0 when nothing requested)
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb2
    import alu_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       id
);

    always_comb begin
        id = REQ0;
        if (&req) begin
            id = ~last;
        end else if (req[1]) begin
            id = REQ1;
        end

        gnt = 2'b00;
        if (|req) begin
            gnt = (id == REQ1) ? 2'b10 : 2'b01;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Shares one ALU between two requesters with round-robin
//             arbitration. One operation in flight at a time; the result
//             is returned to the issuing requester over a valid/ready pair.
//  Ports    : clk, rst (sync, active-high)
//             req{0,1}_valid/ready/a/b/op  - request channels
//             rsp{0,1}_valid/ready         - response handshakes
//             rsp_y/rsp_carry/rsp_zero     - shared response data
//             alu_a/alu_b/alu_s/alu_en     - ALU drive (alu_en: 1 = hold)
//             alu_y/alu_carry/alu_zero     - ALU result
//  Options  : ALU_ARB_STATS_EN adds stats_clr input and gnt0_cnt/gnt1_cnt
//             16-bit saturating grant counters.
//  Revision : 1.0  initial release
// ============================================================================
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DW      = c_DW_DEF,
    parameter int OPW     = c_OPW_DEF,
    parameter int ALU_LAT = c_ALU_LAT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [DW-1:0]   req0_a,
    input  logic [DW-1:0]   req0_b,
    input  logic [OPW-1:0]  req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [DW-1:0]   req1_a,
    input  logic [DW-1:0]   req1_b,
    input  logic [OPW-1:0]  req1_op,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [2*DW-1:0] rsp_y,
    output logic            rsp_carry,
    output logic            rsp_zero,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    output logic [DW-1:0]   alu_s,
    output logic            alu_en,
    input  logic [2*DW-1:0] alu_y,
    input  logic            alu_carry,
    input  logic            alu_zero
`ifdef ALU_ARB_STATS_EN
    ,
    input  logic            stats_clr,
    output logic [15:0]     gnt0_cnt,
    output logic [15:0]     gnt1_cnt
`endif
);

    localparam logic [1:0] c_ST_IDLE  = IDLE;
    localparam logic [1:0] c_ST_ISSUE = ISSUE;
    localparam logic [1:0] c_ST_WAIT  = WAIT;
    localparam logic [1:0] c_ST_RESP  = RESP;
    localparam logic [2:0] c_CNT_LOAD = 3'(ALU_LAT - 1);

    logic [1:0]      r_state;
    logic            r_rr_last;
    logic            r_owner;
    logic [2:0]      r_cnt;
    logic            r_rsp_valid;
    logic [DW-1:0]   r_alu_a;
    logic [DW-1:0]   r_alu_b;
    logic [DW-1:0]   r_alu_s;
    logic [2*DW-1:0] r_rsp_y;
    logic            r_rsp_carry;
    logic            r_rsp_zero;

    logic [1:0]      w_req;
    logic [1:0]      w_gnt;
    logic            w_win;
    logic            w_idle;
    logic            w_accept;
    logic            w_rsp_ready;
    logic [DW-1:0]   w_sel_a;
    logic [DW-1:0]   w_sel_b;
    logic [OPW-1:0]  w_sel_op;

    assign w_req = {req1_valid, req0_valid};

    rr_arb2 u_rr_arb2 (
        .req  (w_req),
        .last (r_rr_last),
        .gnt  (w_gnt),
        .id   (w_win)
    );

    // Ready is only offered in IDLE, so a grant is also the accept.
    assign w_idle     = (r_state == c_ST_IDLE);
    assign req0_ready = w_idle & w_gnt[0];
    assign req1_ready = w_idle & w_gnt[1];
    assign w_accept   = w_idle & (|w_req);

    assign w_sel_a     = (w_win == REQ1) ? req1_a  : req0_a;
    assign w_sel_b     = (w_win == REQ1) ? req1_b  : req0_b;
    assign w_sel_op    = (w_win == REQ1) ? req1_op : req0_op;
    assign w_rsp_ready = (r_owner == REQ1) ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_rr_last   <= REQ1;
            r_owner     <= REQ0;
            r_cnt       <= 3'd0;
            r_rsp_valid <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_s     <= '0;
            r_rsp_y     <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_zero  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_alu_a   <= w_sel_a;
                        r_alu_b   <= w_sel_b;
                        r_alu_s   <= {{(DW-OPW){1'b0}}, w_sel_op};
                        r_owner   <= w_win;
                        r_rr_last <= w_win;
                        r_state   <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    r_cnt   <= c_CNT_LOAD;
                    r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_rsp_y     <= alu_y;
                        r_rsp_carry <= alu_carry;
                        r_rsp_zero  <= alu_zero;
                        r_rsp_valid <= 1'b1;
                        r_state     <= c_ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                c_ST_RESP: begin
                    // No direct issue from here; IDLE re-arbitrates next cycle.
                    if (w_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ALU operates only while the operation is in ISSUE/WAIT.
    assign alu_en     = ~((r_state == c_ST_ISSUE) | (r_state == c_ST_WAIT));
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_s      = r_alu_s;
    assign rsp0_valid = r_rsp_valid & (r_owner == REQ0);
    assign rsp1_valid = r_rsp_valid & (r_owner == REQ1);
    assign rsp_y      = r_rsp_y;
    assign rsp_carry  = r_rsp_carry;
    assign rsp_zero   = r_rsp_zero;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] r_gnt0_cnt;
    logic [15:0] r_gnt1_cnt;

    // Clear has priority over a same-cycle increment; counts saturate.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            r_gnt0_cnt <= 16'd0;
            r_gnt1_cnt <= 16'd0;
        end else begin
            if (req0_valid && req0_ready && (r_gnt0_cnt != 16'hFFFF)) begin
                r_gnt0_cnt <= r_gnt0_cnt + 16'd1;
            end
            if (req1_valid && req1_ready && (r_gnt1_cnt != 16'hFFFF)) begin
                r_gnt1_cnt <= r_gnt1_cnt + 16'd1;
            end
        end
    end

    assign gnt0_cnt = r_gnt0_cnt;
    assign gnt1_cnt = r_gnt1_cnt;
`endif

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Directed self-checking bench for alu_arbiter. Two instances:
//             ALU_LAT=1 for the functional sequences and ALU_LAT=3 for the
//             latency sweep. Each drives a behavioural ALU (op 1 = add).
//  Options  : ALU_ARB_STATS_EN enables the grant-counter sequence.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [15:0] rsp_y;
    logic        rsp_carry, rsp_zero;
    logic [7:0]  alu_a, alu_b, alu_s;
    logic        alu_en;
    logic [15:0] alu_y;
    logic        alu_carry, alu_zero;

    logic        l_req0_valid, l_rsp0_ready;
    logic [7:0]  l_req0_a, l_req0_b;
    logic [3:0]  l_req0_op;
    logic        l_req0_ready, l_req1_ready, l_rsp0_valid, l_rsp1_valid;
    logic [15:0] l_rsp_y;
    logic        l_rsp_carry, l_rsp_zero;
    logic [7:0]  l_alu_a, l_alu_b, l_alu_s;
    logic        l_alu_en;
    logic [15:0] l_alu_y;
    logic        l_alu_carry, l_alu_zero;
    logic [17:0] l_p1, l_p2;

`ifdef ALU_ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] gnt0_cnt, gnt1_cnt, l_gnt0_cnt, l_gnt1_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DW(8), .OPW(4), .ALU_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_y(rsp_y), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_en(alu_en),
        .alu_y(alu_y), .alu_carry(alu_carry), .alu_zero(alu_zero)
`ifdef ALU_ARB_STATS_EN
        , .stats_clr(stats_clr), .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt)
`endif
    );

    alu_arbiter #(.DW(8), .OPW(4), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(l_req0_valid), .req0_ready(l_req0_ready),
        .req0_a(l_req0_a), .req0_b(l_req0_b), .req0_op(l_req0_op),
        .req1_valid(1'b0), .req1_ready(l_req1_ready),
        .req1_a(8'h00), .req1_b(8'h00), .req1_op(4'h0),
        .rsp0_valid(l_rsp0_valid), .rsp0_ready(l_rsp0_ready),
        .rsp1_valid(l_rsp1_valid), .rsp1_ready(1'b1),
        .rsp_y(l_rsp_y), .rsp_carry(l_rsp_carry), .rsp_zero(l_rsp_zero),
        .alu_a(l_alu_a), .alu_b(l_alu_b), .alu_s(l_alu_s), .alu_en(l_alu_en),
        .alu_y(l_alu_y), .alu_carry(l_alu_carry), .alu_zero(l_alu_zero)
`ifdef ALU_ARB_STATS_EN
        , .stats_clr(1'b0), .gnt0_cnt(l_gnt0_cnt), .gnt1_cnt(l_gnt1_cnt)
`endif
    );

    // Behavioural ALU: op 1 = add (carry is bit 8), anything else = AND.
    function automatic logic [17:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] s);
        logic [15:0] y;
        y = (s[3:0] == 4'd1) ? {7'd0, ({1'b0, a} + {1'b0, b})} : {8'd0, a & b};
        return {y[8], (y == 16'd0), y};
    endfunction

    always @(posedge clk) {alu_carry, alu_zero, alu_y} <= alu_f(alu_a, alu_b, alu_s);

    always @(posedge clk) begin
        l_p1 <= alu_f(l_alu_a, l_alu_b, l_alu_s);
        l_p2 <= l_p1;
        {l_alu_carry, l_alu_zero, l_alu_y} <= l_p2;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef ALU_ARB_STATS_EN
    task automatic serve(input bit id);
        int n;
        if (id) req1_valid = 1'b1; else req0_valid = 1'b1;
        n = 0;
        #1;
        while (!(req0_ready || req1_ready) && n < 10) begin tick(); #1; n++; end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 0;
        #1;
        while (!(rsp0_valid || rsp1_valid) && n < 10) begin tick(); #1; n++; end
        check_val("serve_rsp", id ? rsp1_valid : rsp0_valid, 1);
        tick();
    endtask
`endif

    initial begin
        int lat;
        int en0;
        int n;
        bit bad;

        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        l_req0_valid = 0; l_req0_a = 0; l_req0_b = 0; l_req0_op = 0; l_rsp0_ready = 1;
`ifdef ALU_ARB_STATS_EN
        stats_clr = 0;
`endif
        repeat (3) tick();
        rst = 1'b0;
        #1;
        // Reset state
        check_val("rst_req0_ready", req0_ready, 0);
        check_val("rst_rsp0_valid", rsp0_valid, 0);
        check_val("rst_rsp1_valid", rsp1_valid, 0);
        check_val("rst_rsp_y", rsp_y, 0);
        check_val("rst_alu_en", alu_en, 1);
        check_val("rst_alu_a", alu_a, 0);
        check_val("rst_alu_s", alu_s, 0);

        // Single request: 0xEE + 0xEE
        req0_valid = 1; req0_a = 8'hEE; req0_b = 8'hEE; req0_op = 4'd1;
        #1;
        check_val("single_req0_ready", req0_ready, 1);
        check_val("single_req1_ready", req1_ready, 0);
        tick();
        req0_valid = 0;
        #1;
        check_val("single_en_c1", alu_en, 0);
        check_val("single_alu_a", alu_a, 8'hEE);
        check_val("single_alu_s", alu_s, 8'h01);
        check_val("single_ready_c1", req0_ready, 0);
        tick(); #1;
        check_val("single_en_c2", alu_en, 0);
        check_val("single_valid_c2", rsp0_valid, 0);
        tick();
        rsp0_ready = 1;
        #1;
        check_val("single_rsp0_valid", rsp0_valid, 1);
        check_val("single_rsp1_valid", rsp1_valid, 0);
        check_val("single_rsp_y", rsp_y, 16'h01DC);
        check_val("single_carry", rsp_carry, 1);
        check_val("single_zero", rsp_zero, 0);
        check_val("single_en_c3", alu_en, 1);
        tick(); #1;
        check_val("single_valid_clr", rsp0_valid, 0);

        // Contention: both held valid, fresh rr state
        rst = 1; tick(); rst = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        req0_valid = 1; req0_a = 8'h10; req0_b = 8'h01; req0_op = 4'd1;
        req1_valid = 1; req1_a = 8'h20; req1_b = 8'h02; req1_op = 4'd1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            #1;
            while (!(req0_ready || req1_ready) && n < 10) begin tick(); #1; n++; end
            check_val("cont_gnt0", req0_ready, (k % 2 == 0));
            check_val("cont_gnt1", req1_ready, (k % 2 == 1));
            lat = 0;
            bad = 0;
            do begin
                tick(); #1; lat++;
                if (req0_ready || req1_ready) bad = 1;
            end while (!(rsp0_valid || rsp1_valid) && lat < 10);
            check_val("cont_latency", lat, 3);
            check_val("cont_grant_while_busy", bad, 0);
            check_val("cont_rsp0", rsp0_valid, (k % 2 == 0));
            check_val("cont_rsp1", rsp1_valid, (k % 2 == 1));
            check_val("cont_rsp_y", rsp_y, (k % 2 == 0) ? 16'h0011 : 16'h0022);
            tick();
        end
        req0_valid = 0; req1_valid = 0;

        // Backpressure on requester 1 with requester 0 waiting
        rsp1_ready = 0;
        req1_valid = 1; req1_a = 8'h80; req1_b = 8'h80;
        #1;
        check_val("bp_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 0;
        req0_valid = 1; req0_a = 8'h03; req0_b = 8'h04;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val("bp_rsp1_valid", rsp1_valid, 1);
            check_val("bp_rsp_y", rsp_y, 16'h0100);
            check_val("bp_req0_ready", req0_ready, 0);
            tick();
        end
        check_val("bp_carry", rsp_carry, 1);
        rsp1_ready = 1;
        tick(); #1;
        check_val("bp_rsp1_clr", rsp1_valid, 0);
        check_val("bp_req0_accept", req0_ready, 1);
        tick();
        req0_valid = 0;
        tick(); tick(); #1;
        check_val("bp_rsp0_valid", rsp0_valid, 1);
        check_val("bp_rsp0_y", rsp_y, 16'h0007);
        tick();

        // Latency sweep on the ALU_LAT=3 instance: 0 + 0 gives zero flag
        l_req0_valid = 1; l_req0_a = 8'h00; l_req0_b = 8'h00; l_req0_op = 4'd1;
        #1;
        check_val("lat3_ready", l_req0_ready, 1);
        lat = 0;
        en0 = 0;
        while (lat < 15) begin
            tick();
            l_req0_valid = 0;
            #1;
            lat++;
            if (!l_alu_en) en0++;
            if (l_rsp0_valid) break;
        end
        check_val("lat3_latency", lat, 5);
        check_val("lat3_en_cycles", en0, 4);
        check_val("lat3_rsp_y", l_rsp_y, 0);
        check_val("lat3_zero", l_rsp_zero, 1);
        check_val("lat3_carry", l_rsp_carry, 0);
        tick();

        // Reset during WAIT discards the result
        rsp0_ready = 1;
        req0_valid = 1; req0_a = 8'h09; req0_b = 8'h09;
        tick();
        req0_valid = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        #1;
        check_val("rstw_alu_en", alu_en, 1);
        check_val("rstw_rsp0_valid", rsp0_valid, 0);
        check_val("rstw_rsp1_valid", rsp1_valid, 0);
        check_val("rstw_alu_a", alu_a, 0);
        req0_valid = 1; req0_a = 8'h05; req0_b = 8'h06;
        #1;
        check_val("rstw_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 0;
        tick(); tick(); #1;
        check_val("rstw_rsp0_valid_after", rsp0_valid, 1);
        check_val("rstw_rsp_y", rsp_y, 16'h000B);
        tick();

`ifdef ALU_ARB_STATS_EN
        rst = 1; tick(); rst = 0;
        #1;
        check_val("stats_rst0", gnt0_cnt, 0);
        serve(0); serve(0); serve(0); serve(1); serve(1);
        #1;
        check_val("stats_gnt0", gnt0_cnt, 3);
        check_val("stats_gnt1", gnt1_cnt, 2);
        stats_clr = 1;
        tick();
        stats_clr = 0;
        #1;
        check_val("stats_clr0", gnt0_cnt, 0);
        check_val("stats_clr1", gnt1_cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_alu_arbiter
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single 8-bit ALU between two requesters: requester 0 and requester 1 (e.g. a host port and a microsequencer port). Arbitration is round-robin. The block owns the ALU's a/b/s/en inputs and captures y/carry/zero after a fixed ALU latency. It returns each result to the requester that issued the operation, using valid/ready handshakes. It sits directly in front of the ALU instance and is its only driver.

Parameters:
- DW, 8, ALU operand width.
- OPW, 4, ALU opcode width (drives the low OPW bits of the ALU select input; upper select bits are tied 0).
- ALU_LAT, 1, clk cycles from issue until ALU y/carry/zero are valid; legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester has an operation pending.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  DW  operands.
- req0_op / req1_op  in  OPW  ALU opcode.
- rsp0_valid / rsp1_valid  out  1  result available for that requester.
- rsp0_ready / rsp1_ready  in  1  requester takes the result.
- rsp_y  out  2*DW  shared result bus.
- rsp_carry, rsp_zero  out  1  shared flags.
- alu_a, alu_b  out  DW  to ALU operands.
- alu_s  out  DW  to ALU select.
- alu_en  out  1  ALU hold control: 1 = hold, 0 = operate.
- alu_y  in  2*DW  ALU result.
- alu_carry, alu_zero  in  1  ALU flags.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - FSM state = IDLE; rr_last = 1, so requester 0 wins first.
  - req*_ready = 0, rsp*_valid = 0.
  - rsp_y = 0, rsp_carry = 0, rsp_zero = 0.
  - alu_a = alu_b = alu_s = 0; alu_en = 1.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, pick the winner. If both are valid, the winner is the requester other than rr_last; otherwise the sole valid one.
  - Assert the winner's req_ready combinationally in the same cycle. The handshake completes on valid & ready.
  - Register a/b/op onto alu_a/alu_b/alu_s, record owner, update rr_last = owner, go to ISSUE.
  - The loser's ready stays 0.
- ISSUE: alu_en = 0 for this cycle; load wait counter = ALU_LAT-1; go to WAIT.
- WAIT:
  - alu_en stays 0. Decrement the counter.
  - When the counter reaches 0, capture alu_y/carry/zero into rsp_y/rsp_carry/rsp_zero, set rsp<owner>_valid = 1, go to RESP.
  - Total latency from the accept edge to rsp_valid high is ALU_LAT+2 cycles.
- RESP:
  - alu_en = 1. rsp data and valid are held stable until rsp<owner>_ready.
  - On ready: clear valid and go to IDLE. There is no back-to-back issue from RESP, so minimum throughput is one op per ALU_LAT+3 cycles.
- Non-owner rsp_valid is always 0. rsp_y is only meaningful while a valid is high.
- Only one operation is in flight; req_ready is 0 in every state except IDLE.
- Requests arriving during ISSUE/WAIT/RESP wait. Requesters must hold valid and data stable until ready.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1.
- Reset mid-operation: any state returns to IDLE next edge and an in-flight result is discarded, with rsp*_valid = 0 after reset.
- Any other FSM encoding recovers to IDLE.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs gnt0_cnt and gnt1_cnt (16 bits each), incremented on each accept for that requester. They saturate at 0xFFFF and are cleared by rst.
  - Adds input stats_clr (1 bit), which synchronously clears both counters.
  - If stats_clr is high in the same cycle as an increment, the clear wins.
- Undefined: the counter ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package alu_arb_pkg:
  - FSM state enum (IDLE, ISSUE, WAIT, RESP).
  - Requester-id constants REQ0 = 0, REQ1 = 1.
  - Default DW / OPW / ALU_LAT localparams.
- Sub-module rr_arb2: two-input round-robin picker. Inputs are req[1:0] and last; outputs are a one-hot grant and the winner id. It is purely combinational. The last-winner register stays in alu_arbiter.

Test Plan:
- Bench setup: the ALU model performs op 4'b0001 = add (y = a+b, carry = bit 8).
- Single request: req0 a=0xEE, b=0xEE, op=1, ALU_LAT=1 → req0_ready on cycle 0; alu_en=0 for 2 cycles; rsp0_valid at cycle 3 with rsp_y=0x01DC, carry=1, zero=0; rsp1_valid stays 0.
- Contention: req0 and req1 both valid, held continuously for 4 ops → grant order 0,1,0,1; each rsp goes to the correct port; no grant while a response is pending.
- Backpressure: rsp1_ready held low 5 cycles → rsp1_valid and rsp_y stable; req0_ready stays 0 throughout; one cycle after ready, IDLE accepts req0.
- Latency sweep: ALU_LAT=3 → rsp_valid exactly 5 cycles after accept; alu_en=0 for 4 cycles.
- Reset mid-WAIT: assert rst during WAIT → next cycle state IDLE, alu_en=1, both rsp_valid=0; the following req0 is served normally.
- Stats (ALU_ARB_STATS_EN defined): 3 grants to req0, 2 to req1 → gnt0_cnt=3, gnt1_cnt=2; stats_clr pulse → both 0.
